// File: rtl/rc6_loader_if.sv
// Host word bus, core strobe/result bus and debug state between rc6_loader and its neighbours.
// slave = loader side, master = host/core side.
interface rc6_loader_if;
  logic [31:0]  inWord;
  logic         inWordValid;
  logic         inWordIsKey;
  logic         outWordReady;
  logic [127:0] outKey;
  logic [127:0] outData;
  logic         outKeyWr;
  logic         outDataWr;
  logic         inCoreBusy;
  logic [127:0] inCoreResult;
  logic [31:0]  outResWord;
  logic         outResValid;
  logic         inResReady;
  logic         outBusy;
  logic         outError;
  logic [2:0]   dbgState;

  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a held valid keeps its word stable until taken.
  modport slave (
    input  inWord, inWordValid, inWordIsKey, inCoreBusy, inCoreResult, inResReady,
    output outWordReady, outKey, outData, outKeyWr, outDataWr,
           outResWord, outResValid, outBusy, outError, dbgState
  );

  modport master (
    output inWord, inWordValid, inWordIsKey, inCoreBusy, inCoreResult, inResReady,
    input  outWordReady, outKey, outData, outKeyWr, outDataWr,
           outResWord, outResValid, outBusy, outError, dbgState
  );
endinterface

// File: rtl/rc6_loader.sv
// Loads key/plaintext words for the RC6 core, strobes it, waits on busy, then streams the result.
// Optional watchdog on the wait states: define RC6_LOADER_TIMEOUT_EN.
module rc6_loader (
  input logic         inClk,
  input logic         inReset,
  rc6_loader_if.slave bus
);
  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 4;
  localparam int BLK_W     = WORD_W * BLK_WORDS;

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [BLK_W-1:0]  r_key, r_data, r_result;
  logic [1:0]        r_kidx, r_didx, r_ridx;
  logic              r_key_valid, r_data_valid;
  logic              r_wr;
  logic              r_res_valid;
  logic [WORD_W-1:0] r_res_word;
  logic              r_error;

  logic       w_accept, w_key_acc, w_data_acc;
  logic       w_key_valid_nxt, w_data_valid_nxt;
  logic       w_capture, w_res_hs, w_timeout;
  logic [1:0] w_ridx_inc;

`ifdef RC6_LOADER_TIMEOUT_EN
  logic [7:0] r_wdog;
  // r_wdog counts completed cycles in the current wait state.
  assign w_timeout = ((r_state == S_WAIT_RISE) && !bus.inCoreBusy && (r_wdog == 8'd4)) ||
                     ((r_state == S_WAIT_FALL) &&  bus.inCoreBusy && (r_wdog == 8'd200));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_accept         = bus.inWordValid && (r_state == S_LOAD);
    w_key_acc        = w_accept && bus.inWordIsKey;
    w_data_acc       = w_accept && !bus.inWordIsKey;
    w_key_valid_nxt  = r_key_valid;
    if (w_key_acc) w_key_valid_nxt = !r_key_valid && (r_kidx == 2'd3);
    w_data_valid_nxt = r_data_valid || (w_data_acc && (r_didx == 2'd3));
    w_capture        = (r_state == S_WAIT_FALL) && !bus.inCoreBusy;
    w_res_hs         = (r_state == S_DRAIN) && r_res_valid && bus.inResReady;
    w_ridx_inc       = r_ridx + 2'd1;

    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:      if (w_key_valid_nxt && w_data_valid_nxt) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: if (bus.inCoreBusy) w_state_nxt = S_WAIT_FALL;
                   else if (w_timeout) w_state_nxt = S_LOAD;
      S_WAIT_FALL: if (!bus.inCoreBusy) w_state_nxt = S_DRAIN;
                   else if (w_timeout) w_state_nxt = S_LOAD;
      S_DRAIN:     if (w_res_hs && (r_ridx == 2'd3)) w_state_nxt = S_LOAD;
      default:     w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inReset) begin
      r_state      <= S_LOAD;
      r_key        <= '0;
      r_data       <= '0;
      r_result     <= '0;
      r_kidx       <= 2'd0;
      r_didx       <= 2'd0;
      r_ridx       <= 2'd0;
      r_key_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_wr         <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_word   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr         <= (r_state == S_LOAD) && (w_state_nxt == S_START);
      r_key_valid  <= w_key_valid_nxt;
      r_data_valid <= w_data_valid_nxt;
      // A key word after a complete key restarts loading at slot 0.
      if (w_key_acc) begin
        if (r_key_valid) begin
          r_key[WORD_W-1:0] <= bus.inWord;
          r_kidx            <= 2'd1;
        end else begin
          r_key[{r_kidx, 5'd0} +: WORD_W] <= bus.inWord;
          r_kidx                          <= r_kidx + 2'd1;
        end
      end
      if (w_data_acc) begin
        r_data[{r_didx, 5'd0} +: WORD_W] <= bus.inWord;
        r_didx                           <= r_didx + 2'd1;
      end
      if (w_capture) begin
        r_result     <= bus.inCoreResult;
        r_res_word   <= bus.inCoreResult[WORD_W-1:0];
        r_res_valid  <= 1'b1;
        r_ridx       <= 2'd0;
        r_data_valid <= 1'b0;
        r_didx       <= 2'd0;
      end
      if (w_res_hs) begin
        r_ridx <= w_ridx_inc;
        if (r_ridx == 2'd3) r_res_valid <= 1'b0;
        else                r_res_word  <= r_result[{w_ridx_inc, 5'd0} +: WORD_W];
      end
      if (w_timeout) begin
        r_data_valid <= 1'b0;
        r_didx       <= 2'd0;
      end
    end
  end

`ifdef RC6_LOADER_TIMEOUT_EN
  always_ff @(posedge inClk) begin
    if (inReset) begin
      r_wdog  <= 8'd0;
      r_error <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_wdog <= 8'd0;
      else if ((r_state == S_WAIT_RISE) || (r_state == S_WAIT_FALL)) r_wdog <= r_wdog + 8'd1;
      if (w_timeout)     r_error <= 1'b1;
      else if (w_accept) r_error <= 1'b0;
    end
  end
`else
  assign r_error = 1'b0;
`endif

  assign bus.outWordReady = (r_state == S_LOAD);
  assign bus.outBusy      = (r_state != S_LOAD);
  assign bus.outKey       = r_key;
  assign bus.outData      = r_data;
  assign bus.outKeyWr     = r_wr;
  assign bus.outDataWr    = r_wr;
  assign bus.outResWord   = r_res_word;
  assign bus.outResValid  = r_res_valid;
  assign bus.outError     = r_error;
  assign bus.dbgState     = r_state;
endmodule

// File: tb/tb_rc6_loader.sv
// Self-checking bench for rc6_loader: directed vector table, reset abort, then randomized
// blocks checked against a word-level reference model and a result-word scoreboard.
module tb_rc6_loader;
  logic inClk = 1'b0;
  logic inReset = 1'b1;

  rc6_loader_if bus ();

  rc6_loader dut (
    .inClk  (inClk),
    .inReset(inReset),
    .bus    (bus.slave)
  );

  always #5 inClk = ~inClk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: key/data slots and word counts since the last (re)start.
  logic [31:0] m_key[4];
  logic [31:0] m_data[4];
  int m_kc, m_dc;

  typedef struct {
    logic         is_key;
    logic [31:0]  word;
    logic         exp_fire;
    logic         chk_key;
    logic [127:0] exp_key;
    int           busy_len;
    int           drain_mode;
  } vec_t;

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_kc = 0;
    m_dc = 0;
    for (int i = 0; i < 4; i++) begin
      m_key[i]  = '0;
      m_data[i] = '0;
    end
  endtask

  function automatic logic model_predict_fire(input logic is_key);
    int kc = m_kc;
    int dc = m_dc;
    if (is_key) kc = (kc == 4) ? 1 : kc + 1;
    else        dc = dc + 1;
    return (kc == 4) && (dc == 4);
  endfunction

  task automatic send_word(input logic is_key, input logic [31:0] w, input logic exp_fire,
                           input string nm);
    int n = 0;
    bus.inWordValid = 1'b1;
    bus.inWordIsKey = is_key;
    bus.inWord      = w;
    while (!bus.outWordReady && n < 50) begin
      tick();
      n++;
    end
    if (!bus.outWordReady) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout: got 0 expected 1", nm);
    end
    tick();
    bus.inWordValid = 1'b0;
    if (is_key) begin
      if (m_kc == 4) m_kc = 0;
      m_key[m_kc] = w;
      m_kc++;
    end else begin
      m_data[m_dc] = w;
      m_dc++;
    end
    check({nm, " strobe"}, {bus.outKeyWr, bus.outDataWr}, exp_fire ? 2'b11 : 2'b00);
    if (exp_fire) begin
      check({nm, " key"},  bus.outKey,  {m_key[3], m_key[2], m_key[1], m_key[0]});
      check({nm, " data"}, bus.outData, {m_data[3], m_data[2], m_data[1], m_data[0]});
      m_dc = 0;
    end
  endtask

  // Starts in the START cycle; busy is held for busy_len further cycles.
  task automatic core_run(input int busy_len, input logic [127:0] res);
    logic ready_seen = 1'b0;
    bus.inCoreBusy = 1'b1;
    tick();
    check("strobe one cycle", {bus.outKeyWr, bus.outDataWr}, 2'b00);
    check("busy in wait", bus.outBusy, 1'b1);
    bus.inWordValid = 1'b1;
    bus.inWordIsKey = 1'b1;
    bus.inWord      = $urandom;
    repeat (busy_len) begin
      tick();
      if (bus.outWordReady) ready_seen = 1'b1;
    end
    check("ready low while core busy", ready_seen, 1'b0);
    bus.inWordValid  = 1'b0;
    bus.inCoreBusy   = 1'b0;
    bus.inCoreResult = res;
    for (int i = 0; i < 4; i++) exp_q.push_back(res[32*i +: 32]);
  endtask

  // mode 0: always ready, 1: toggling, 2: random
  task automatic drain(input int mode);
    int budget = 0;
    int got = 0;
    logic prev_stall = 1'b0;
    logic ready;
    logic [31:0] prev_word = '0;
    while (got < 4 && budget < 100) begin
      ready = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(budget % 2) : logic'($urandom_range(0, 1));
      if (prev_stall) begin
        check("valid held", bus.outResValid, 1'b1);
        check("word held",  bus.outResWord,  prev_word);
      end
      if (bus.outResValid) begin
        check("result word", bus.outResWord, exp_q.size() > 0 ? exp_q[0] : 32'hxxxxxxxx);
        if (ready) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      prev_stall      = bus.outResValid && !ready;
      prev_word       = bus.outResWord;
      bus.inResReady  = ready;
      tick();
      budget++;
    end
    bus.inResReady = 1'b0;
    if (got < 4) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: got %0d words expected 4", got);
    end
    check("back to load", {bus.outResValid, bus.outBusy, bus.outWordReady}, 3'b001);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " key"},   bus.outKey,      '0);
    check({nm, " data"},  bus.outData,     '0);
    check({nm, " ctrl"},  {bus.outKeyWr, bus.outDataWr, bus.outResValid, bus.outBusy,
                           bus.outWordReady, bus.outError}, 6'b000010);
    check({nm, " rword"}, bus.outResWord,  '0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[24];
    logic [127:0] ka;
    logic [127:0] kb;
    logic [127:0] res;
    logic is_key;
    int iter;

    bus.inWord = '0;
    bus.inWordValid = 1'b0;
    bus.inWordIsKey = 1'b0;
    bus.inCoreBusy = 1'b0;
    bus.inCoreResult = '0;
    bus.inResReady = 1'b0;
    model_reset();

    tick();
    tick();
    check_reset_outputs("reset");
    inReset = 1'b0;
    tick();
    check_reset_outputs("after reset");

    ka = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    kb = {32'hA0000004, 32'hA0000003, 32'hA0000006, 32'hA0000005};
    for (int i = 0; i < 24; i++) tbl[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tbl[i]    = '{1'b1, 32'h03020100 + 32'h04040404 * i, 1'b0, 1'b0, 128'h0, 0, 0};
      tbl[i+12] = '{1'b1, 32'hA0000001 + i, 1'b0, 1'b0, 128'h0, 0, 0};
      tbl[i+18] = '{1'b0, 32'hD0000001 + i, 1'b0, 1'b0, 128'h0, 0, 0};
    end
    tbl[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, ka, 152, 1};
    tbl[8]  = '{1'b0, 32'h11111111, 1'b0, 1'b0, 128'h0, 0, 0};
    tbl[9]  = '{1'b0, 32'h22222222, 1'b0, 1'b0, 128'h0, 0, 0};
    tbl[10] = '{1'b0, 32'h33333333, 1'b0, 1'b0, 128'h0, 0, 0};
    tbl[11] = '{1'b0, 32'h44444444, 1'b1, 1'b1, ka, 20, 2};
    tbl[16] = '{1'b1, 32'hA0000005, 1'b0, 1'b0, 128'h0, 0, 0};
    tbl[17] = '{1'b1, 32'hA0000006, 1'b0, 1'b1, kb, 0, 0};
    tbl[21].chk_key = 1'b1;
    tbl[21].exp_key = kb;
    tbl[22] = '{1'b1, 32'hA0000007, 1'b0, 1'b0, 128'h0, 0, 0};
    tbl[23] = '{1'b1, 32'hA0000008, 1'b1, 1'b1,
                {32'hA0000008, 32'hA0000007, 32'hA0000006, 32'hA0000005}, 5, 0};

    for (int i = 0; i < 24; i++) begin
      send_word(tbl[i].is_key, tbl[i].word, tbl[i].exp_fire, $sformatf("vec%0d", i));
      if (tbl[i].chk_key) check($sformatf("vec%0d table key", i), bus.outKey, tbl[i].exp_key);
      if (tbl[i].exp_fire) begin
        res = (i == 7) ? 128'h8FC3A536_56B1F778_C129DF4E_9848A41E
                       : {$urandom, $urandom, $urandom, $urandom};
        core_run(tbl[i].busy_len, res);
        drain(tbl[i].drain_mode);
      end
    end

    // Reset while the core is busy: block aborted, key cleared.
    for (int i = 0; i < 4; i++) send_word(1'b0, $urandom, i == 3, "abort blk");
    bus.inCoreBusy = 1'b1;
    tick();
    tick();
    tick();
    check("in wait_fall", {bus.outBusy, bus.outWordReady}, 2'b10);
    inReset = 1'b1;
    tick();
    check_reset_outputs("mid reset");
    inReset = 1'b0;
    bus.inCoreBusy = 1'b0;
    model_reset();
    tick();
    check_reset_outputs("post mid reset");

    for (int b = 0; b < 25; b++) begin
      iter = 0;
      while (iter < 40) begin
        if (m_dc == 4)     is_key = 1'b1;
        else if (m_kc < 4) is_key = logic'($urandom_range(0, 1));
        else               is_key = ($urandom_range(0, 9) == 0);
        if (model_predict_fire(is_key)) begin
          send_word(is_key, $urandom, 1'b1, "rand fire");
          break;
        end
        send_word(is_key, $urandom, 1'b0, "rand word");
        iter++;
      end
      if (iter < 40) begin
        core_run($urandom_range(1, 30), {$urandom, $urandom, $urandom, $urandom});
        drain($urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
